// File: rtl/jk_pkg.sv
// Shared JK command encoding and next-state rule for the
// JK counter cells.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_t;

   function automatic logic jk_next(
      input jk_cmd_t cmd,
      input logic    q
   );
      logic n;
      n = q;
      unique case (cmd)
         JK_HOLD:   n = q;
         JK_RESET:  n = 1'b0;
         JK_SET:    n = 1'b1;
         JK_TOGGLE: n = ~q;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jk_ff.sv
// Rising-edge JK flip-flop, synchronous active-high reset
// to q=0.
module jk_ff
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_q;
   logic q_d;

   // next state from the {j,k} command
   always_comb begin
      q_d = jk_next(jk_cmd_t'({j, k}), q_q);
   end

   // state register, reset dominates the command
   always_ff @(posedge clk) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= q_d;
   end

   assign q    = q_q;
   assign qbar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// W-bit synchronous up/down counter from JK cells.
// Define JK_COUNTER_MODULO_EN for modulo-MOD counting.
module jk_sync_counter
   import jk_pkg::*;
#(
   parameter int W   = 4,
   parameter int MOD = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         tc
);

   logic [W-1:0] q_w;
   logic [W-1:0] qbar_unused;
   logic [W-1:0] j_w;
   logic [W-1:0] k_w;
   logic [W-1:0] low_ones;
   logic [W-1:0] low_zeros;
   logic         wrap_up;
   logic         wrap_dn;

`ifdef JK_COUNTER_MODULO_EN
   localparam logic [W-1:0] TOP = W'(MOD - 1);

   // wrap at or past the top; loaded out-of-range values clear too
   assign wrap_up = up & (q_w >= TOP);
   assign wrap_dn = ~up & (q_w == '0);
`else
   localparam logic [W-1:0] TOP = '1;

   logic unused_mod;
   assign unused_mod = (MOD != 0);

   // binary wrap falls out of the plain toggle chain
   assign wrap_up = 1'b0;
   assign wrap_dn = 1'b0;
`endif

   // per-bit j/k steering: load, then count, else hold
   always_comb begin
      jk_cmd_t c;
      low_ones     = '0;
      low_zeros    = '0;
      j_w          = '0;
      k_w          = '0;
      low_ones[0]  = 1'b1;
      low_zeros[0] = 1'b1;
      for (int i = 1; i < W; i++) begin
         low_ones[i]  = low_ones[i-1] & q_w[i-1];
         low_zeros[i] = low_zeros[i-1] & ~q_w[i-1];
      end
      for (int i = 0; i < W; i++) begin
         c = JK_HOLD;
         if (load) begin
            c = d[i] ? JK_SET : JK_RESET;
         end else if (en) begin
            if (wrap_up) begin
               c = JK_RESET;
            end else if (wrap_dn) begin
               c = TOP[i] ? JK_SET : JK_RESET;
            end else if (up ? low_ones[i] : low_zeros[i]) begin
               c = JK_TOGGLE;
            end
         end
         j_w[i] = c[1];
         k_w[i] = c[0];
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_bit
      jk_ff u_ff (
         .clk  (clk),
         .rst  (rst),
         .j    (j_w[i]),
         .k    (k_w[i]),
         .q    (q_w[i]),
         .qbar (qbar_unused[i])
      );
   end

   // terminal count for cascading; not gated by load or rst
   always_comb begin
      tc = en & ((up & (q_w == TOP)) | (~up & (q_w == '0)));
   end

   assign q = q_w;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (W=4).
// Modulo checks run when JK_COUNTER_MODULO_EN is defined.
module tb_jk_sync_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic [3:0] q;
   logic       tc;

   int tests = 0;
   int fails = 0;

   jk_sync_counter #(.W(4), .MOD(10)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .d    (d),
      .q    (q),
      .tc   (tc)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string      tag,
      input logic [7:0] obs,
      input logic [7:0] exp
   );
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] e;

      // T1 reset dominates load and en
      rst = 1; en = 1; load = 1; d = 4'd5; up = 1;
      step(); chk("t1_rst_e1", q, 0);
      step(); chk("t1_rst_e2", q, 0);
      rst = 0; en = 0; load = 0;
      step(); chk("t1_idle_e1", q, 0);
      step(); chk("t1_idle_e2", q, 0);

`ifdef JK_COUNTER_MODULO_EN
      // T6 modulo-10 up wrap
      rst = 1; step(); rst = 0;
      en = 1; up = 1;
      e = 4'd0;
      for (int n = 0; n < 10; n++) begin
         #1;
         chk("t6_tc_up", tc, (e == 4'd9) ? 1 : 0);
         step();
         e = (e == 4'd9) ? 4'd0 : e + 4'd1;
         chk("t6_q_up", q, e);
      end
      chk("t6_q_wrapped", q, 0);
      // down from 0 loads MOD-1
      up = 0; #1;
      chk("t6_tc_dn", tc, 1);
      step(); chk("t6_dn_wrap", q, 9);
      step(); chk("t6_dn_8", q, 8);
      // out-of-range load clears on an up edge
      load = 1; d = 4'd12; step(); load = 0;
      chk("t6_load12", q, 12);
      up = 1; step(); chk("t6_oor_up", q, 0);
      // out-of-range down is a plain decrement
      load = 1; d = 4'd12; step(); load = 0;
      up = 0; step(); chk("t6_oor_dn", q, 11);
`else
      // T2 up count through the wrap
      rst = 1; step(); rst = 0;
      en = 1; up = 1;
      e = 4'd0;
      for (int n = 0; n < 17; n++) begin
         #1;
         chk("t2_tc", tc, (e == 4'd15) ? 1 : 0);
         step();
         e = e + 4'd1;
         chk("t2_q", q, e);
      end
      chk("t2_final", q, 1);

      // T3 down wrap
      rst = 1; step(); rst = 0;
      en = 1; up = 0; #1;
      chk("t3_tc0", tc, 1);
      step(); chk("t3_q15", q, 15);
      chk("t3_tc15", tc, 0);
      step(); chk("t3_q14", q, 14);

      // T4 load beats count
      en = 0; load = 1; d = 4'd3; step();
      chk("t4_q3", q, 3);
      load = 1; d = 4'd9; en = 1; up = 1; step();
      chk("t4_q9", q, 9);
      load = 0; step(); chk("t4_q10", q, 10);
      // tc ignores load
      load = 1; d = 4'd15; en = 0; step();
      chk("t4_q15", q, 15);
      d = 4'd2; en = 1; up = 1; #1;
      chk("t4_tc_load", tc, 1);
      step(); chk("t4_q2", q, 2);
      load = 0;
`endif

      // T5 hold and reset mid-count
      rst = 1; step(); rst = 0;
      en = 1; up = 1;
      for (int n = 0; n < 7; n++) step();
      chk("t5_q7", q, 7);
      en = 0;
      for (int n = 0; n < 3; n++) begin
         step(); chk("t5_hold", q, 7);
      end
      rst = 1; en = 1; step(); rst = 0;
      chk("t5_rst", q, 0);
      en = 0; up = 0; #1;
      chk("t5_tc_noen", tc, 0);
      en = 1; up = 1; step();
      chk("t5_resume", q, 1);
      up = 0; step();
      chk("t5_dir", q, 0);
      step();
`ifdef JK_COUNTER_MODULO_EN
      chk("t5_dn_wrap", q, 9);
`else
      chk("t5_dn_wrap", q, 15);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
